// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave fronting a NUM_REGS-word register file with read-only slots,
// byte-strobe writes, DECERR/SLVERR decode and one-entry AW/W buffering.

module axi4_lite_regfile_word #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH-1:0]   q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (strb[b]) q[b*8 +: 8] <= data[b*8 +: 8];
            end
        end
    end
endmodule

module axi4_lite_regfile_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic                           s_AWVALID,
    input  logic [2:0]                     s_AWPROT,
    input  logic [ADDR_WIDTH-1:0]          s_AWADDR,
    output logic                           s_AWREADY,
    input  logic                           s_WVALID,
    input  logic [DATA_WIDTH-1:0]          s_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        s_WSTRB,
    output logic                           s_WREADY,
    input  logic                           s_BREADY,
    output logic                           s_BVALID,
    output logic [1:0]                     s_BRESP,
    input  logic                           s_ARVALID,
    input  logic [2:0]                     s_ARPROT,
    input  logic [ADDR_WIDTH-1:0]          s_ARADDR,
    output logic                           s_ARREADY,
    input  logic                           s_RREADY,
    output logic                           s_RVALID,
    output logic [1:0]                     s_RRESP,
    output logic [DATA_WIDTH-1:0]          s_RDATA,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int SW   = DATA_WIDTH/8;
    localparam int OFF  = $clog2(SW);
    localparam int IW   = ADDR_WIDTH - OFF;
    localparam int SELW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SW-1:0]         strb;
    } wbeat_t;

    function automatic logic [1:0] dec_resp(input logic [IW-1:0] idx, input logic wr);
        if (idx >= IW'(NUM_REGS)) return RESP_DECERR;
        if (wr && RO_MASK[idx[SELW-1:0]]) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] hw_w;

    assign hw_w    = hw_in;
    assign reg_out = reg_q;

    // ---------------- write path ----------------
    logic                  aw_full, w_full;
    logic [ADDR_WIDTH-1:0] aw_q;
    wbeat_t                w_q;
    logic                  aw_hs, w_hs, commit, wr_ok;
    logic [ADDR_WIDTH-1:0] wa;
    wbeat_t                wb;
    logic [1:0]            wresp;
    logic [SELW-1:0]       wsel;

    assign s_AWREADY = !aw_full;
    assign s_WREADY  = !w_full;
    assign aw_hs     = s_AWVALID && !aw_full;
    assign w_hs      = s_WVALID && !w_full;

    // A beat handshaking this cycle is used directly, bypassing its buffer.
    assign wa     = aw_full ? aw_q : s_AWADDR;
    assign wb     = w_full ? w_q : '{data: s_WDATA, strb: s_WSTRB};
    assign commit = (aw_full || aw_hs) && (w_full || w_hs) && (!s_BVALID || s_BREADY);
    assign wresp  = dec_resp(wa[ADDR_WIDTH-1:OFF], 1'b1);
    assign wsel   = wa[OFF +: SELW];
    assign wr_ok  = commit && (wresp == RESP_OKAY);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_q     <= '0;
            w_q      <= '0;
            s_BVALID <= 1'b0;
            s_BRESP  <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                s_BVALID <= 1'b1;
                s_BRESP  <= wresp;
                if (wresp == RESP_OKAY) wr_pulse[wsel] <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_q    <= s_AWADDR;
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_q    <= '{data: s_WDATA, strb: s_WSTRB};
                end
                if (s_BREADY) s_BVALID <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_q[i] = '0;
        end else begin : g_rw
            axi4_lite_regfile_word #(
                .DATA_WIDTH (DATA_WIDTH),
                .RESET_VALUE(RESET_VALUE)
            ) u_word (
                .clk (iCLK),
                .rst (iRST),
                .we  (wr_ok && (wsel == SELW'(i))),
                .strb(wb.strb),
                .data(wb.data),
                .q   (reg_q[i])
            );
        end
    end

    // ---------------- read path ----------------
    logic                  ar_hs;
    logic [1:0]            rresp;
    logic [SELW-1:0]       rsel;
    logic [DATA_WIDTH-1:0] rdata_d;

    assign s_ARREADY = !s_RVALID || s_RREADY;
    assign ar_hs     = s_ARVALID && s_ARREADY;
    assign rresp     = dec_resp(s_ARADDR[ADDR_WIDTH-1:OFF], 1'b0);
    assign rsel      = s_ARADDR[OFF +: SELW];
    // reg_q reflects the pre-commit value, so a same-cycle write is not visible.
    assign rdata_d   = (rresp == RESP_DECERR) ? '0 :
                       (RO_MASK[rsel] ? hw_w[rsel] : reg_q[rsel]);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s_RVALID <= 1'b0;
            s_RRESP  <= RESP_OKAY;
            s_RDATA  <= '0;
        end else if (ar_hs) begin
            s_RVALID <= 1'b1;
            s_RRESP  <= rresp;
            s_RDATA  <= rdata_d;
        end else if (s_RREADY) begin
            s_RVALID <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_AWPROT, s_ARPROT, wa[OFF-1:0], s_ARADDR[OFF-1:0]};
endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Randomized bench for axi4_lite_regfile_slave: transactions are checked against
// a word-array model of the register file and its decode rules.

module tb_axi4_lite_regfile_slave;
    localparam int              AW = 32;
    localparam int              DW = 32;
    localparam int              NR = 16;
    localparam logic [NR-1:0]   RO = 16'h0004;
    localparam logic [DW-1:0]   RV = 32'h1234_5678;

    logic             clk = 1'b0;
    logic             rst;
    logic             awvalid, wvalid, bready, arvalid, rready;
    logic [2:0]       awprot, arprot;
    logic [AW-1:0]    awaddr, araddr;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic             awready, wready, bvalid, arready, rvalid;
    logic [1:0]       bresp, rresp;
    logic [DW-1:0]    rdata;
    logic [NR*DW-1:0] hw_in, reg_out;
    logic [NR-1:0]    wr_pulse;

    always #5 clk = ~clk;

    axi4_lite_regfile_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VALUE(RV)
    ) dut (
        .iCLK(clk), .iRST(rst),
        .s_AWVALID(awvalid), .s_AWPROT(awprot), .s_AWADDR(awaddr), .s_AWREADY(awready),
        .s_WVALID(wvalid), .s_WDATA(wdata), .s_WSTRB(wstrb), .s_WREADY(wready),
        .s_BREADY(bready), .s_BVALID(bvalid), .s_BRESP(bresp),
        .s_ARVALID(arvalid), .s_ARPROT(arprot), .s_ARADDR(araddr), .s_ARREADY(arready),
        .s_RREADY(rready), .s_RVALID(rvalid), .s_RRESP(rresp), .s_RDATA(rdata),
        .hw_in(hw_in), .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] mdl [NR];

    task automatic chk(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic wr);
        logic [31:0] idx;
        idx = a >> 2;
        if (idx >= NR) return 2'b11;
        if (wr && RO[idx[3:0]]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [NR*DW-1:0] exp_regs();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? 32'h0 : mdl[i];
        return v;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] idx;
        idx = a >> 2;
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx[3:0]][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        logic [1:0] er;
        logic [NR-1:0] ep;
        logic [31:0] idx;
        er = exp_resp(a, 1'b1);
        idx = a >> 2;
        ep = '0;
        @(negedge clk);
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 1;
        t = 0;
        while (!(awready && wready) && t < 20) begin @(negedge clk); t++; end
        chk("wr_ready", (t < 20), 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        if (er == 2'b00) begin
            mdl_write(a, d, s);
            ep[idx[3:0]] = 1'b1;
        end
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, er);
        chk("wr_pulse", wr_pulse, ep);
        chk("wr_regs", reg_out, exp_regs());
        @(negedge clk);
        chk("wr_bvalid_clr", bvalid, 0);
        chk("wr_pulse_clr", wr_pulse, 0);
    endtask

    task automatic do_rd(input logic [31:0] a);
        int t;
        logic [1:0] er;
        logic [31:0] ed, idx;
        er = exp_resp(a, 1'b0);
        idx = a >> 2;
        if (er == 2'b11) ed = 0;
        else if (RO[idx[3:0]]) ed = hw_in[idx[3:0]*DW +: DW];
        else ed = mdl[idx[3:0]];
        @(negedge clk);
        arvalid = 1; araddr = a; rready = 0;
        t = 0;
        while (!arready && t < 20) begin @(negedge clk); t++; end
        chk("rd_ready", (t < 20), 1);
        @(negedge clk);
        arvalid = 0;
        chk("rd_rvalid", rvalid, 1);
        chk("rd_rdata", rdata, ed);
        chk("rd_rresp", rresp, er);
        @(negedge clk);
        chk("rd_rvalid_hold", rvalid, 1);
        chk("rd_rdata_hold", rdata, ed);
        rready = 1;
        @(negedge clk);
        chk("rd_rvalid_clr", rvalid, 0);
        rready = 0;
    endtask

    task automatic check_reset_state();
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulse", wr_pulse, 0);
        chk("rst_regs", reg_out, exp_regs());
    endtask

    initial begin
        logic [31:0] a;
        rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awprot = 0; arprot = 0; awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        hw_in = '0;
        for (int i = 0; i < NR; i++) mdl[i] = RV;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_reset_state();

        // basic write, strobe merge, readback
        do_wr(32'h04, 32'hDEAD_BEEF, 4'hF);
        do_wr(32'h04, 32'h1122_3344, 4'h5);
        do_rd(32'h04);

        // W three cycles ahead of AW, then a second write queued behind a stalled B
        @(negedge clk);
        wvalid = 1; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; bready = 0;
        chk("wf_wready", wready, 1);
        @(negedge clk);
        wvalid = 0;
        chk("wf_wready_drop", wready, 0);
        repeat (2) begin
            @(negedge clk);
            chk("wf_no_commit", bvalid, 0);
        end
        awvalid = 1; awaddr = 32'h0C;
        chk("wf_awready", awready, 1);
        @(negedge clk);
        awvalid = 0;
        mdl[3] = 32'hA5A5_0F0F;
        chk("wf_bvalid", bvalid, 1);
        chk("wf_bresp", bresp, 2'b00);
        chk("wf_pulse", wr_pulse, 16'h0008);
        chk("wf_regs", reg_out, exp_regs());
        awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("q_awready", awready, 0);
        chk("q_wready", wready, 0);
        chk("q_bvalid", bvalid, 1);
        chk("q_bresp_old", bresp, 2'b00);
        chk("q_pulse", wr_pulse, 0);
        repeat (2) begin
            @(negedge clk);
            chk("q_bvalid_hold", bvalid, 1);
            chk("q_bresp_hold", bresp, 2'b00);
        end
        bready = 1;
        @(negedge clk);
        chk("q_b2b_bvalid", bvalid, 1);
        chk("q_b2b_bresp", bresp, 2'b10);
        chk("q_b2b_pulse", wr_pulse, 0);
        chk("q_b2b_regs", reg_out, exp_regs());
        chk("q_awready_back", awready, 1);
        @(negedge clk);
        chk("q_bvalid_clr", bvalid, 0);

        // read-only slot
        hw_in[2*DW +: DW] = 32'hCAFE_0000;
        do_rd(32'h08);
        do_wr(32'h08, 32'h0000_1234, 4'hF);
        do_rd(32'h08);

        // out-of-range decode
        do_rd(32'h40);
        do_wr(32'h40, 32'hFFFF_FFFF, 4'hF);
        do_rd(32'h43);

        // reset while both responses and an AW buffer are pending
        @(negedge clk);
        awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h10; bready = 0; rready = 0;
        @(negedge clk);
        wvalid = 0; arvalid = 0;
        chk("pr_bvalid", bvalid, 1);
        chk("pr_rvalid", rvalid, 1);
        awaddr = 32'h14;
        @(negedge clk);
        awvalid = 0;
        chk("pr_aw_buffered", awready, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < NR; i++) mdl[i] = RV;
        check_reset_state();
        // a lone W after reset must not pair with a stale AW
        bready = 1;
        wvalid = 1; wdata = 32'h7777_8888; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 0;
        repeat (2) begin
            @(negedge clk);
            chk("pr_no_stale", bvalid, 0);
        end
        awvalid = 1; awaddr = 32'h14;
        @(negedge clk);
        awvalid = 0;
        mdl[5] = 32'h7777_8888;
        chk("pr_bvalid2", bvalid, 1);
        chk("pr_pulse2", wr_pulse, 16'h0020);
        chk("pr_regs2", reg_out, exp_regs());
        @(negedge clk);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                do_wr(a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                if ($urandom_range(0, 3) == 0) hw_in[2*DW +: DW] = $urandom;
                do_rd(a);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
